// File: rtl/pipeline_cmd_issuer.sv
// Purpose : host-side command master; decodes a framed byte stream into
//           instruction/register writes, SRAM delay allocations and full resets.
// Latency : fields and the ISSUE state follow the edge that accepts the last
//           argument byte; write strobes rise one cycle later.
// Backpres: byte_ready is high only while idle or collecting argument bytes.
//           Nothing is buffered, so the next frame waits until this command completes.
// Ports   : clk/reset (async, active-high); byte_in/byte_valid/byte_ready byte stream;
//           block_target, reg_target, instr_val, ctrl_data command fields;
//           instr_write/reg_write strobes with matching acks;
//           alloc_sram_delay and full_reset single-cycle pulses; resetting from the pipeline;
//           busy, err_code (sticky) and cmd_count status.
module pipeline_cmd_issuer #(
  parameter int n_blocks       = 256,
  parameter int reg_addr_width = 4,
  parameter int instr_width    = 32,
  parameter int data_width     = 16,
  parameter int ack_timeout    = 1023,
  localparam int BW = (n_blocks > 1) ? $clog2(n_blocks) : 1,
  localparam int RW = reg_addr_width
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic [BW-1:0]          block_target,
  output logic [BW+RW-1:0]       reg_target,
  output logic [instr_width-1:0] instr_val,
  output logic                   instr_write,
  input  logic                   instr_write_ack,
  output logic [data_width-1:0]  ctrl_data,
  output logic                   reg_write,
  input  logic                   reg_write_ack,
  output logic                   alloc_sram_delay,
  output logic                   full_reset,
  input  logic                   resetting,
  output logic                   busy,
  output logic [1:0]             err_code,
  output logic [15:0]            cmd_count
);

  // Argument bits of the longest frame: INSTR is block + word, REG is block + reg + data.
  localparam int ARG_W = ((8 + instr_width) > (16 + data_width)) ? (8 + instr_width) : (16 + data_width);
  localparam int TW    = $clog2(ack_timeout + 1);

  localparam logic [7:0] INSTR_ARGS = 8'(1 + instr_width / 8);
  localparam logic [7:0] REG_ARGS   = 8'(2 + data_width / 8);
  localparam logic [7:0] ALLOC_ARGS = 8'(data_width / 8);
  // Last wait cycle: a wait phase lasts at most ack_timeout cycles.
  localparam logic [TW-1:0] TO_LAST = TW'(ack_timeout - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARGS, S_ISSUE, S_WAIT_ACK, S_ALLOC, S_RST_PULSE, S_RST_WAIT
  } state_t;

  typedef enum logic [1:0] {K_INSTR, K_REG, K_ALLOC} kind_t;

  state_t            state, state_nxt;
  kind_t             kind;
  logic [7:0]        arg_cnt;
  logic [ARG_W-9:0]  arg_sr;
  logic [ARG_W-1:0]  arg_next;
  logic [TW-1:0]     timer;

  logic byte_fire, last_arg, ack_seen, timer_last;
  logic wait_done, rst_done, cmd_done, timed_out;

  // Bytes are shifted in MSB first, so the frame's last byte lands in the low bits.
  assign arg_next   = {arg_sr, byte_in};
  assign byte_fire  = byte_valid && byte_ready;
  assign last_arg   = (state == S_ARGS) && byte_fire && (arg_cnt == 8'd1);
  assign ack_seen   = (kind == K_INSTR) ? instr_write_ack : reg_write_ack;
  assign timer_last = (timer == TO_LAST);
  assign wait_done  = (state == S_WAIT_ACK) && ack_seen;
  // The first RST_WAIT cycle (timer == 0) ignores resetting; the pipeline may not have raised it yet.
  assign rst_done   = (state == S_RST_WAIT) && (timer != '0) && !resetting;
  assign cmd_done   = wait_done || rst_done || (state == S_ALLOC);
  assign timed_out  = ((state == S_WAIT_ACK) || (state == S_RST_WAIT)) && timer_last &&
                      !wait_done && !rst_done;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (byte_fire) begin
          if (byte_in == 8'h01 || byte_in == 8'h02 || byte_in == 8'h03) state_nxt = S_ARGS;
          else if (byte_in == 8'h04)                                      state_nxt = S_RST_PULSE;
        end
      end
      S_ARGS:      if (last_arg) state_nxt = (kind == K_ALLOC) ? S_ALLOC : S_ISSUE;
      S_ISSUE:     state_nxt = S_WAIT_ACK;
      S_WAIT_ACK:  if (wait_done || timed_out) state_nxt = S_IDLE;
      S_ALLOC:     state_nxt = S_IDLE;
      S_RST_PULSE: state_nxt = S_RST_WAIT;
      S_RST_WAIT:  if (rst_done || timed_out) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state. Write strobes live only in WAIT_ACK, so they rise
  // on the edge leaving ISSUE and fall on the edge that samples the ack.
  always_comb begin
    byte_ready       = 1'b0;
    busy             = 1'b0;
    instr_write      = 1'b0;
    reg_write        = 1'b0;
    alloc_sram_delay = 1'b0;
    full_reset       = 1'b0;
    byte_ready       = (state == S_IDLE) || (state == S_ARGS);
    busy             = (state != S_IDLE);
    instr_write      = (state == S_WAIT_ACK) && (kind == K_INSTR);
    reg_write        = (state == S_WAIT_ACK) && (kind == K_REG);
    alloc_sram_delay = (state == S_ALLOC);
    full_reset       = (state == S_RST_PULSE);
  end

  // Frame decode, field capture, wait timer and status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kind         <= K_INSTR;
      arg_cnt      <= '0;
      arg_sr       <= '0;
      timer        <= '0;
      block_target <= '0;
      reg_target   <= '0;
      instr_val    <= '0;
      ctrl_data    <= '0;
      err_code     <= 2'd0;
      cmd_count    <= 16'd0;
    end else begin
      if ((state == S_IDLE) && byte_fire) begin
        case (byte_in)
          8'h01:   begin kind <= K_INSTR; arg_cnt <= INSTR_ARGS; end
          8'h02:   begin kind <= K_REG;   arg_cnt <= REG_ARGS;   end
          8'h03:   begin kind <= K_ALLOC; arg_cnt <= ALLOC_ARGS; end
          8'h04:   begin end
          default: if (err_code == 2'd0) err_code <= 2'd1;
        endcase
      end

      if ((state == S_ARGS) && byte_fire) begin
        arg_sr  <= arg_next[ARG_W-9:0];
        arg_cnt <= arg_cnt - 8'd1;
        if (arg_cnt == 8'd1) begin
          case (kind)
            K_INSTR: begin
              block_target <= arg_next[instr_width +: BW];
              instr_val    <= arg_next[instr_width-1:0];
            end
            K_REG: begin
              reg_target <= {arg_next[data_width + 8 +: BW], arg_next[data_width +: RW]};
              ctrl_data  <= arg_next[data_width-1:0];
            end
            default: ctrl_data <= arg_next[data_width-1:0];
          endcase
        end
      end

      if ((state == S_ISSUE) || (state == S_RST_PULSE))          timer <= '0;
      else if ((state == S_WAIT_ACK) || (state == S_RST_WAIT))   timer <= timer + TW'(1);

      if (cmd_done) cmd_count <= cmd_count + 16'd1;
      if (timed_out && (err_code == 2'd0)) err_code <= 2'd2;
    end
  end

endmodule

// File: doc/pipeline_cmd_issuer.md
Name: pipeline_cmd_issuer

Overview:
- Host-side command master for the DSP pipeline's control port.
- Consumes a framed byte stream (from the SPI/UART bridge) and decodes instruction writes, register writes, SRAM delay allocations and full resets.
- Drives the pipeline's command strobes and waits for its acks, with a timeout.
- Sits between the host bridge and the pipeline sequencer; it is the initiator for the command interface that the pipeline answers.

Parameters:
- n_blocks, 256, number of pipeline blocks; block index width is BW = $clog2(n_blocks), and BW ≤ 8.
- reg_addr_width, 4, block register address width RW, with RW ≤ 8.
- instr_width, 32, instruction word width; a multiple of 8.
- data_width, 16, control data width; a multiple of 8.
- ack_timeout, 1023, maximum cycles to wait for an ack or for reset completion.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- byte_in  in  8  command stream byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  issuer accepts a byte; a transfer occurs when byte_valid && byte_ready.
- block_target  out  BW  target block for an instruction write.
- reg_target  out  BW+RW  register target, formed as {block, reg}.
- instr_val  out  instr_width  instruction word.
- instr_write  out  1  instruction write strobe.
- instr_write_ack  in  1  instruction write acknowledge.
- ctrl_data  out  data_width  register value or allocation size.
- reg_write  out  1  register write strobe.
- reg_write_ack  in  1  register write acknowledge.
- alloc_sram_delay  out  1  single-cycle delay allocation pulse.
- full_reset  out  1  single-cycle full reset pulse.
- resetting  in  1  pipeline reset in progress.
- busy  out  1  high whenever state is not IDLE.
- err_code  out  2  sticky error code: 0 none, 1 bad opcode, 2 timeout.
- cmd_count  out  16  count of completed commands; wraps modulo 2^16.

Behaviour:
- Reset values: all outputs are 0, except byte_ready = 1; state is IDLE; every counter is 0.
- Framing: multi-byte fields are sent MSB first. Block and reg fields are one byte each; only their low BW and RW bits are used.
- Opcode 0x01, INSTR: block, then instr_width/8 bytes. Ends in a 1-cycle ISSUE, then WAIT_ACK.
- Opcode 0x02, REG: block, reg, then data_width/8 bytes. ISSUE, then WAIT_ACK.
- Opcode 0x03, ALLOC: data_width/8 size bytes. Then ctrl_data = size and alloc_sram_delay = 1 for exactly one cycle; no ack is expected; the command completes the following cycle.
- Opcode 0x04, FRST: no argument bytes. full_reset = 1 for one cycle, then RST_WAIT.
- Any other opcode: err_code is set to 1 if it is currently 0. The byte is consumed and the issuer stays in IDLE; cmd_count is unchanged.
- States: IDLE, ARGS (byte counter loaded per opcode), ISSUE, WAIT_ACK, ALLOC, RST_PULSE, RST_WAIT.
- byte_ready is high only in IDLE and ARGS. It is low from the cycle after the last argument byte is accepted until the return to IDLE.
- Target and data outputs (block_target, reg_target, instr_val, ctrl_data) are registered when the last argument byte is accepted. They hold stable until the next command's fields are loaded.
- ISSUE raises instr_write or reg_write. The strobe stays high through WAIT_ACK.
- WAIT_ACK:
  - Acks are sampled starting in the first WAIT_ACK cycle.
  - On ack = 1, the strobe is cleared at that edge, cmd_count is incremented, and the state returns to IDLE.
  - An ack arriving on the same cycle as ISSUE is ignored.
  - Acks that arrive outside WAIT_ACK are ignored.
- Timeout: a cycle counter is cleared on entry to WAIT_ACK or RST_WAIT. If it reaches ack_timeout without completion:
  - the strobe drops;
  - err_code is set to 2 if it is currently 0;
  - the state returns to IDLE;
  - cmd_count is not incremented.
- RST_WAIT: resetting is ignored in the first cycle of RST_WAIT. From the second cycle on, resetting = 0 completes the command: cmd_count is incremented and the state returns to IDLE.
- err_code is sticky (first error wins) and is cleared only by reset.
- Asserting reset mid-command returns the issuer to IDLE immediately and deasserts all strobes asynchronously. A partially received frame is discarded.
- At most one strobe (instr_write, reg_write, alloc_sram_delay, full_reset) is high in any cycle.
- The implementation has no buffering: a new frame is not accepted until the previous command completes.

Test Plan:
- INSTR write: stream 01 05 DE AD BE EF; the pipeline model acks 3 cycles after instr_write rises. Required: block_target = 5 and instr_val = 0xDEADBEEF while instr_write is high; instr_write is high for exactly 4 cycles; cmd_count = 1; byte_ready is low until the issuer returns to IDLE.
- REG write: stream 02 0A 03 12 34 with the ack tied high. Required: reg_target = 0xA3, ctrl_data = 0x1234, reg_write is high for 1 cycle, cmd_count increments.
- ALLOC then FRST: stream 03 02 00, then 04; resetting is high for 10 cycles after full_reset. Required: alloc_sram_delay pulses once with ctrl_data = 0x0200; full_reset pulses once; busy is held until resetting falls; cmd_count = 2.
- Timeout and bad opcode: stream 02 00 00 00 01 with no ack, then 7F, then 02 00 01 00 02 with an ack. Required: after 1023 cycles reg_write drops and err_code = 2; 7F is consumed and err_code stays 2; the next REG command completes normally.
- Reset mid-frame: send 01 05 DE, assert reset, release it, then send a full REG frame. Required: all outputs return to their reset values; no instr_write occurs; the REG frame is decoded correctly.
- Backpressure: toggle byte_valid randomly during 50 mixed frames. Required: every command completes with correct fields, and cmd_count = 50.
